nonrestoring_divider_32b: RTL

- Iterative 32-bit integer divider, signed and unsigned, using the non-restoring algorithm. Each step is one add or subtract of the divisor.
- Sits beside the ALU as the multi-cycle DIV/REM unit. It is the inverse operation to the combinational adder/multiplier path and reuses the team's 32-bit adder-subtractor for every step.
- start/busy/done handshake to the execute stage. Results hold until the next accepted start.

---
 rtl/nonrestoring_divider_32b_pkg.sv | 16 +
 rtl/nonrestoring_divider_32b_addsub.sv | 47 ++++
 rtl/nonrestoring_divider_32b.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/nonrestoring_divider_32b_pkg.sv
// Shared constants and state encoding for the iterative non-restoring divider.
package nonrestoring_divider_32b_pkg;

    localparam int unsigned WIDTH = 32;

    localparam logic [WIDTH-1:0] DIV_ZERO_QUOT       = 32'hFFFF_FFFF;
    localparam logic [WIDTH-1:0] SIGNED_OVF_DIVIDEND = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CORRECT = 2'd2,
        FINISH  = 2'd3
    } div_state_t;

endpackage

// File: rtl/nonrestoring_divider_32b_addsub.sv
// 32-bit Brent-Kung prefix adder-subtractor: sum = a + b (sub=0) or a - b (sub=1).
module brent_kung_adder_subtractor_32b
    import nonrestoring_divider_32b_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] gg;
    logic [WIDTH-1:0] pp;
    logic [WIDTH:0]   c;

    always_comb begin
        b_eff = b ^ {WIDTH{sub}};
        g     = a & b_eff;
        p     = a ^ b_eff;
        gg    = g;
        pp    = p;
        // Up-sweep builds group (G,P) at power-of-two boundaries; down-sweep fills the gaps.
        for (int unsigned lvl = 0; lvl < 5; lvl++) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (((i + 1) % (2 << lvl)) == 0) begin
                    gg[5'(i)] = gg[5'(i)] | (pp[5'(i)] & gg[5'(i - (1 << lvl))]);
                    pp[5'(i)] = pp[5'(i)] & pp[5'(i - (1 << lvl))];
                end
            end
        end
        for (int unsigned k = 0; k < 4; k++) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if ((((i + 1) % (16 >> k)) == (8 >> k)) && (i >= (16 >> k))) begin
                    gg[5'(i)] = gg[5'(i)] | (pp[5'(i)] & gg[5'(i - (8 >> k))]);
                    pp[5'(i)] = pp[5'(i)] & pp[5'(i - (8 >> k))];
                end
            end
        end
        c    = {gg | (pp & {WIDTH{sub}}), sub};
        sum  = p ^ c[WIDTH-1:0];
        cout = c[WIDTH];
    end

endmodule

// File: rtl/nonrestoring_divider_32b.sv
// Multi-cycle signed/unsigned 32-bit DIV/REM unit, one non-restoring add/sub step per cycle.
module nonrestoring_divider_32b #(
    parameter int unsigned WIDTH = nonrestoring_divider_32b_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    import nonrestoring_divider_32b_pkg::*;

    localparam int unsigned CNT_W = 6;

    div_state_t       state;
    div_state_t       state_nxt;

    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [CNT_W-1:0] cnt_q;
    logic             q_neg_q;
    logic             r_neg_q;

    logic             start_ok;
    logic             is_zero;
    logic             is_ovf;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] add_a;
    logic             add_sub;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH:0]   r_step;
    logic [WIDTH-1:0] r_fix;

    assign start_ok = start && ((state == IDLE) || (state == FINISH));
    assign is_zero  = (divisor == '0);
    assign is_ovf   = signed_op && (dividend == SIGNED_OVF_DIVIDEND) && (divisor == '1);
    assign sign_a   = signed_op & dividend[WIDTH-1];
    assign sign_b   = signed_op & divisor[WIDTH-1];
    assign abs_a    = sign_a ? -dividend : dividend;
    assign abs_b    = sign_b ? -divisor : divisor;

    // One adder serves both the RUN step and the final remainder restore.
    assign r_shift  = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign add_a    = (state == CORRECT) ? r_q[WIDTH-1:0] : r_shift[WIDTH-1:0];
    assign add_sub  = (state == RUN) & ~r_q[WIDTH];

    brent_kung_adder_subtractor_32b u_addsub (
        .a    (add_a),
        .b    (d_q),
        .sub  (add_sub),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Bit 32 of the 33-bit result recovered from the 32-bit adder's carry.
    assign r_step = {r_shift[WIDTH] ^ add_sub ^ add_cout, add_sum};
    assign r_fix  = r_q[WIDTH] ? add_sum : r_q[WIDTH-1:0];

    assign busy = (state == RUN) || (state == CORRECT);
    assign done = (state == FINISH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FINISH: begin
                if (start) begin
                    state_nxt = (is_zero || is_ovf) ? FINISH : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_nxt = CORRECT;
                end
            end
            CORRECT: state_nxt = FINISH;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (start_ok) begin
            if (is_zero) begin
                quotient    <= DIV_ZERO_QUOT;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else if (is_ovf) begin
                quotient    <= SIGNED_OVF_DIVIDEND;
                remainder   <= '0;
                div_by_zero <= 1'b0;
            end else begin
                r_q     <= '0;
                q_q     <= abs_a;
                d_q     <= abs_b;
                cnt_q   <= '0;
                q_neg_q <= sign_a ^ sign_b;
                r_neg_q <= sign_a;
            end
        end else if (state == RUN) begin
            r_q   <= r_step;
            q_q   <= {q_q[WIDTH-2:0], ~r_step[WIDTH]};
            cnt_q <= cnt_q + 1'b1;
        end else if (state == CORRECT) begin
            quotient    <= q_neg_q ? -q_q : q_q;
            remainder   <= r_neg_q ? -r_fix : r_fix;
            div_by_zero <= 1'b0;
        end
    end

endmodule
